// File: rtl/if_id_stage_reg.sv
// if_id_stage_reg: IF/ID pipeline register with stall/flush, exception merge and saturating perf counters
module if_id_stage_reg #(
  parameter int DW = 32,
  parameter int EXC_W = 5,
  parameter logic [DW-1:0] PC_LO = DW'(32'h0000_3000),
  parameter logic [DW-1:0] PC_HI = DW'(32'h0000_4FFC),
  parameter logic [EXC_W-1:0] EXC_ADEL = EXC_W'(4),
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             flush,
  input  logic             valid_in,
  input  logic [DW-1:0]    ir,
  input  logic [DW-1:0]    pc,
  input  logic [EXC_W-1:0] exc_in,
  input  logic             bd_in,
  output logic [DW-1:0]    ir_d,
  output logic [DW-1:0]    pc_d,
  output logic [DW-1:0]    pc4_d,
  output logic [DW-1:0]    pc8_d,
  output logic [EXC_W-1:0] exc_d,
  output logic             bd_d,
  output logic             valid_d,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);
  logic bad, adel;
  logic [EXC_W-1:0] exc_nx;
  // upstream exception codes always take precedence over the local address check
  always_comb begin
    bad = (pc[1:0] != 2'b00) || (pc < PC_LO) || (pc > PC_HI);
    adel = (exc_in == '0) && valid_in && bad;
    exc_nx = (exc_in != '0) ? exc_in : adel ? EXC_ADEL : '0;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      ir_d <= '0;
      pc_d <= PC_LO;
      pc4_d <= PC_LO + DW'(4);
      pc8_d <= PC_LO + DW'(8);
      exc_d <= '0;
      bd_d <= 1'b0;
      valid_d <= 1'b0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else if (flush) begin
      ir_d <= '0;
      pc_d <= pc;
      pc4_d <= pc + DW'(4);
      pc8_d <= pc + DW'(8);
      exc_d <= '0;
      bd_d <= 1'b0;
      valid_d <= 1'b0;
      flush_cnt <= flush_cnt + CNT_W'(flush_cnt != '1);
    end else if (stall) begin
      stall_cnt <= stall_cnt + CNT_W'(valid_d && (stall_cnt != '1));
    end else begin
      ir_d <= adel ? '0 : ir;
      pc_d <= pc;
      pc4_d <= pc + DW'(4);
      pc8_d <= pc + DW'(8);
      exc_d <= exc_nx;
      bd_d <= bd_in;
      valid_d <= valid_in;
    end
  end
endmodule

// File: tb/tb_if_id_stage_reg.sv
// tb_if_id_stage_reg: vector table, directed corner sequences and randomized run against a reference model
module tb_if_id_stage_reg;
  logic clk = 0, reset = 1, stall = 0, flush = 0, valid_in = 0, bd_in = 0;
  logic [31:0] ir = 0, pc = 0;
  logic [4:0] exc_in = 0;
  logic [31:0] ir_d, pc_d, pc4_d, pc8_d, ir_d4, pc_d4, pc4_d4, pc8_d4;
  logic [4:0] exc_d, exc_d4;
  logic bd_d, valid_d, bd_d4, valid_d4;
  logic [15:0] stall_cnt, flush_cnt;
  logic [3:0] stall_cnt4, flush_cnt4;
  int checks = 0, failures = 0;
  logic [31:0] m_ir, m_pc, m_pc4, m_pc8;
  logic [4:0] m_exc;
  logic m_bd, m_valid;
  int m_sc, m_fc, m_sc4, m_fc4;

  always #5 clk = ~clk;

  if_id_stage_reg dut (.clk(clk), .reset(reset), .stall(stall), .flush(flush), .valid_in(valid_in),
    .ir(ir), .pc(pc), .exc_in(exc_in), .bd_in(bd_in), .ir_d(ir_d), .pc_d(pc_d), .pc4_d(pc4_d),
    .pc8_d(pc8_d), .exc_d(exc_d), .bd_d(bd_d), .valid_d(valid_d), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt));

  if_id_stage_reg #(.CNT_W(4)) dut4 (.clk(clk), .reset(reset), .stall(stall), .flush(flush), .valid_in(valid_in),
    .ir(ir), .pc(pc), .exc_in(exc_in), .bd_in(bd_in), .ir_d(ir_d4), .pc_d(pc_d4), .pc4_d(pc4_d4),
    .pc8_d(pc8_d4), .exc_d(exc_d4), .bd_d(bd_d4), .valid_d(valid_d4), .stall_cnt(stall_cnt4), .flush_cnt(flush_cnt4));

  typedef struct {
    logic vin; logic [31:0] ir, pc; logic [4:0] exc; logic bd;
    logic [31:0] e_ir, e_pc4, e_pc8; logic [4:0] e_exc; logic e_bd, e_valid;
  } vec_t;
  vec_t vt[10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic int sat(input int v, input int mx);
    return v < mx ? v + 1 : mx;
  endfunction

  // reference model: applies the priority rules reset > flush > stall > load directly
  task automatic model_edge();
    bit bad, adel;
    if (reset) begin
      m_ir = 0; m_pc = 32'h3000; m_pc4 = 32'h3004; m_pc8 = 32'h3008;
      m_exc = 0; m_bd = 0; m_valid = 0; m_sc = 0; m_fc = 0; m_sc4 = 0; m_fc4 = 0;
    end else if (flush) begin
      m_ir = 0; m_pc = pc; m_pc4 = pc + 4; m_pc8 = pc + 8; m_exc = 0; m_bd = 0; m_valid = 0;
      m_fc = sat(m_fc, 65535); m_fc4 = sat(m_fc4, 15);
    end else if (stall) begin
      if (m_valid) begin m_sc = sat(m_sc, 65535); m_sc4 = sat(m_sc4, 15); end
    end else begin
      bad = (pc % 4 != 0) || (pc < 32'h3000) || (pc > 32'h4FFC);
      adel = exc_in == 0 && valid_in && bad;
      m_exc = exc_in != 0 ? exc_in : adel ? 5'd4 : 5'd0;
      m_ir = adel ? 32'h0 : ir;
      m_pc = pc; m_pc4 = pc + 4; m_pc8 = pc + 8; m_bd = bd_in; m_valid = valid_in;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("ir_d", ir_d, m_ir);
    chk("pc_d", pc_d, m_pc);
    chk("pc4_d", pc4_d, m_pc4);
    chk("pc8_d", pc8_d, m_pc8);
    chk("exc_d", exc_d, m_exc);
    chk("bd_d", bd_d, m_bd);
    chk("valid_d", valid_d, m_valid);
    chk("stall_cnt", stall_cnt, 64'(m_sc));
    chk("flush_cnt", flush_cnt, 64'(m_fc));
    chk("stall_cnt4", stall_cnt4, 64'(m_sc4));
    chk("flush_cnt4", flush_cnt4, 64'(m_fc4));
  endtask

  initial begin
    vt[0] = '{1, 32'h2408_0001, 32'h3000, 0, 0, 32'h2408_0001, 32'h3004, 32'h3008, 0, 0, 1};
    vt[1] = '{1, 32'h1234_5678, 32'h3002, 0, 0, 32'h0, 32'h3006, 32'h300A, 4, 0, 1};
    vt[2] = '{1, 32'hAAAA_5555, 32'h5000, 0, 0, 32'h0, 32'h5004, 32'h5008, 4, 0, 1};
    vt[3] = '{0, 32'hAAAA_5555, 32'h5000, 0, 0, 32'hAAAA_5555, 32'h5004, 32'h5008, 0, 0, 0};
    vt[4] = '{1, 32'h0BAD_F00D, 32'h3002, 10, 0, 32'h0BAD_F00D, 32'h3006, 32'h300A, 10, 0, 1};
    vt[5] = '{0, 32'h0000_0001, 32'hFFFF_FFFC, 0, 0, 32'h1, 32'h0, 32'h4, 0, 0, 0};
    vt[6] = '{1, 32'h0000_0001, 32'hFFFF_FFFC, 0, 0, 32'h0, 32'h0, 32'h4, 4, 0, 1};
    vt[7] = '{1, 32'h0340_0008, 32'h4FFC, 0, 1, 32'h0340_0008, 32'h5000, 32'h5004, 0, 1, 1};
    vt[8] = '{1, 32'h0340_0008, 32'h2FFC, 0, 1, 32'h0, 32'h3000, 32'h3004, 4, 1, 1};
    vt[9] = '{1, 32'h0340_0008, 32'h4FFD, 0, 0, 32'h0, 32'h5001, 32'h5005, 4, 0, 1};
    // reset held two cycles with random inputs
    reset = 1; ir = $urandom; pc = $urandom; valid_in = 1; stall = 1; flush = 1; exc_in = 5'($urandom);
    step(); step();
    chk("rst_pc_d", pc_d, 32'h3000);
    chk("rst_pc4_d", pc4_d, 32'h3004);
    chk("rst_pc8_d", pc8_d, 32'h3008);
    chk("rst_valid_d", valid_d, 0);
    chk("rst_cnts", {stall_cnt, flush_cnt}, 0);
    // load then stall three cycles with changing inputs
    reset = 0; stall = 0; flush = 0; ir = 32'h2408_0001; pc = 32'h3000; valid_in = 1; exc_in = 0; bd_in = 0;
    step();
    chk("load_ir_d", ir_d, 32'h2408_0001);
    chk("load_pc8_d", pc8_d, 32'h3008);
    stall = 1;
    for (int i = 0; i < 3; i++) begin ir = $urandom; pc = $urandom; step(); end
    chk("hold_ir_d", ir_d, 32'h2408_0001);
    chk("hold_pc_d", pc_d, 32'h3000);
    chk("stall_cnt3", stall_cnt, 3);
    // flush beats stall; then a stalled bubble is not counted
    flush = 1; pc = 32'h3010;
    step();
    chk("fl_valid_d", valid_d, 0);
    chk("fl_ir_d", ir_d, 0);
    chk("fl_pc_d", pc_d, 32'h3010);
    chk("fl_flush_cnt", flush_cnt, 1);
    chk("fl_stall_cnt", stall_cnt, 3);
    flush = 0;
    step(); step();
    chk("bubble_stall_cnt", stall_cnt, 3);
    chk("bubble_valid_d", valid_d, 0);
    // saturation of the 4-bit counter
    stall = 0; pc = 32'h3020; valid_in = 1;
    step();
    stall = 1;
    for (int i = 0; i < 20; i++) step();
    chk("sat_stall_cnt4", stall_cnt4, 15);
    chk("sat_stall_cnt", stall_cnt, 23);
    // reset while stalled with nonzero counters
    reset = 1;
    step();
    chk("rst_mid_cnts", {stall_cnt, flush_cnt, 8'(stall_cnt4), 8'(flush_cnt4)}, 0);
    chk("rst_mid_pc_d", pc_d, 32'h3000);
    reset = 0; stall = 0;
    for (int i = 0; i < 10; i++) begin
      valid_in = vt[i].vin; ir = vt[i].ir; pc = vt[i].pc; exc_in = vt[i].exc; bd_in = vt[i].bd;
      step();
      chk($sformatf("vec%0d_ir_d", i), ir_d, vt[i].e_ir);
      chk($sformatf("vec%0d_pc4_d", i), pc4_d, vt[i].e_pc4);
      chk($sformatf("vec%0d_pc8_d", i), pc8_d, vt[i].e_pc8);
      chk($sformatf("vec%0d_exc_d", i), exc_d, vt[i].e_exc);
      chk($sformatf("vec%0d_bd_d", i), bd_d, vt[i].e_bd);
      chk($sformatf("vec%0d_valid_d", i), valid_d, vt[i].e_valid);
    end
    for (int i = 0; i < 400; i++) begin
      reset = $urandom_range(0, 49) == 0;
      flush = $urandom_range(0, 7) == 0;
      stall = $urandom_range(0, 3) == 0;
      valid_in = $urandom_range(0, 3) != 0;
      ir = $urandom;
      pc = $urandom_range(0, 3) == 0 ? $urandom : 32'h2FF0 + 32'($urandom_range(0, 'h2020));
      exc_in = $urandom_range(0, 7) == 0 ? 5'($urandom) : 5'd0;
      bd_in = 1'($urandom);
      step();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
